// File: rtl/dfp_burst_adapter.sv
// Converts one 256-bit DFP line read/write into a 4-beat 64-bit bmem burst; read resp 6 cycles after accept, write 5.
// Backpressure: bmem_ready stalls the read request and each write beat; DFP requests are held until the dfp_resp pulse.
module dfp_burst_adapter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  dfp_addr,
  input  logic         dfp_read,
  input  logic         dfp_write,
  input  logic [255:0] dfp_wdata,
  output logic [255:0] dfp_rdata,
  output logic [31:0]  dfp_raddr,
  output logic         dfp_resp,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [31:0]  bmem_raddr,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  localparam int BEATS = 4;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_BURST, RD_RESP, WR_BURST, WR_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   line_addr_q, line_addr_d;
  logic [255:0]  wbuf_q, wbuf_d;
  logic [255:0]  lbuf_q, lbuf_d;
  logic [255:0]  rdata_q, rdata_d;
  logic [31:0]   raddr_q, raddr_d;
  logic          last_beat;
  logic          unused_bits;

  assign unused_bits = ^{dfp_addr[4:0], bmem_raddr[4:0]};
  assign last_beat   = (cnt_q == 2'(BEATS - 1));
  assign dfp_rdata   = rdata_q;
  assign dfp_raddr   = raddr_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_addr_d = line_addr_q;
    wbuf_d      = wbuf_q;
    lbuf_d      = lbuf_q;
    rdata_d     = rdata_q;
    raddr_d     = raddr_q;
    dfp_resp    = 1'b0;
    bmem_addr   = '0;
    bmem_read   = 1'b0;
    bmem_write  = 1'b0;
    bmem_wdata  = '0;

    case (state_q)
      IDLE: begin
        // Write has priority; a concurrent read stays pending until IDLE returns.
        if (dfp_write) begin
          line_addr_d = {dfp_addr[31:5], 5'b0};
          wbuf_d      = dfp_wdata;
          cnt_d       = '0;
          state_d     = WR_BURST;
        end else if (dfp_read) begin
          line_addr_d = {dfp_addr[31:5], 5'b0};
          cnt_d       = '0;
          state_d     = RD_REQ;
        end
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = line_addr_q;
        if (bmem_ready) state_d = RD_BURST;
      end
      RD_BURST: begin
        if (bmem_rvalid && (bmem_raddr[31:5] == line_addr_q[31:5])) begin
          lbuf_d[{cnt_q, 6'b0} +: 64] = bmem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (last_beat) begin
            // Response registers load with the completed line so they stay stable mid-burst.
            rdata_d = lbuf_d;
            raddr_d = line_addr_q;
            state_d = RD_RESP;
          end
        end
      end
      RD_RESP: begin
        dfp_resp = 1'b1;
        state_d  = IDLE;
      end
      WR_BURST: begin
        bmem_write = 1'b1;
        bmem_addr  = line_addr_q;
        bmem_wdata = wbuf_q[{cnt_q, 6'b0} +: 64];
        if (bmem_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (last_beat) begin
            raddr_d = line_addr_q;
            state_d = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        dfp_resp = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_addr_q <= '0;
      wbuf_q      <= '0;
      lbuf_q      <= '0;
      rdata_q     <= '0;
      raddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_addr_q <= line_addr_d;
      wbuf_q      <= wbuf_d;
      lbuf_q      <= lbuf_d;
      rdata_q     <= rdata_d;
      raddr_q     <= raddr_d;
    end
  end

endmodule

// File: tb/tb_dfp_burst_adapter.sv
// Bench for dfp_burst_adapter: reactive bmem model plus a response scoreboard.
module tb_dfp_burst_adapter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  dfp_addr;
  logic         dfp_read, dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic [31:0]  dfp_raddr;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  always #5 clk = ~clk;

  dfp_burst_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
    .dfp_rdata(dfp_rdata), .dfp_raddr(dfp_raddr), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [255:0] rdata;
    logic [31:0]  raddr;
    int           lat;
    int           acc;
  } resp_t;

  resp_t        sb[$];
  logic [31:0]  exp_ra[$];
  logic [63:0]  exp_wd[$];
  logic [31:0]  exp_wa[$];
  logic [255:0] mem [logic [31:0]];
  logic [255:0] last_rd = '0;

  // Memory model configuration, written only by the stimulus process.
  int          stall_cfg = 0;
  int          gap_cfg = 0;
  bit          inject_cfg = 1'b0;
  bit          wr_toggle_cfg = 1'b0;
  int          stray_req = 0;
  logic [31:0] stray_addr = '0;

  // bmem model and response monitor: samples at negedge, drives inputs for the next posedge.
  initial begin : mem_model
    int stall_left, gap_left, beat_idx, stray_done;
    bit bursting, req_active, injected, wr_phase, prev_wr, prev_resp;
    logic [31:0] burst_addr;
    logic [255:0] ln;
    resp_t e;
    stall_left = 0; gap_left = 0; beat_idx = 0; stray_done = 0;
    bursting = 0; req_active = 0; injected = 0; wr_phase = 0; prev_wr = 0; prev_resp = 0;
    burst_addr = '0;
    bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
    forever begin
      @(negedge clk);
      bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
      if (dfp_resp) begin
        check("resp_back_to_back", 256'(prev_resp), '0);
        if (sb.size() == 0) check("unexpected_resp", 256'(1), '0);
        else begin
          e = sb.pop_front();
          check("dfp_rdata", dfp_rdata, e.rdata);
          check("dfp_raddr", 256'(dfp_raddr), 256'(e.raddr));
          if (e.lat > 0) check("resp_latency", 256'(cyc - e.acc), 256'(e.lat));
        end
      end
      prev_resp = dfp_resp;
      if (bmem_read || bmem_write) check("rd_wr_exclusive", 256'(bmem_read & bmem_write), '0);
      if (bmem_read) begin
        if (!req_active) begin
          req_active = 1;
          stall_left = stall_cfg;
        end
        if (stall_left > 0) stall_left--;
        else begin
          bmem_ready = 1'b1; req_active = 0; bursting = 1; beat_idx = 0;
          gap_left = gap_cfg; injected = 0; burst_addr = bmem_addr;
          if (exp_ra.size() == 0) check("unexpected_rd_req", 256'(1), '0);
          else check("bmem_rd_addr", 256'(bmem_addr), 256'(exp_ra.pop_front()));
        end
      end else if (bmem_write) begin
        if (!prev_wr) wr_phase = 1;
        bmem_ready = wr_toggle_cfg ? wr_phase : 1'b1;
        wr_phase = !wr_phase;
        if (bmem_ready) begin
          if (exp_wd.size() == 0) check("unexpected_wr_beat", 256'(1), '0);
          else begin
            check("wr_beat", 256'(bmem_wdata), 256'(exp_wd.pop_front()));
            check("wr_addr", 256'(bmem_addr), 256'(exp_wa.pop_front()));
          end
        end
      end else if (bursting) begin
        if (gap_left > 0) gap_left--;
        else if (inject_cfg && !injected && beat_idx == 2) begin
          bmem_rvalid = 1'b1; bmem_raddr = burst_addr ^ 32'h0000_0100;
          bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0; injected = 1; gap_left = gap_cfg;
        end else begin
          ln = mem.exists(burst_addr) ? mem[burst_addr] : '0;
          bmem_rvalid = 1'b1; bmem_raddr = burst_addr | 32'h0000_0008;
          bmem_rdata = ln[64*beat_idx +: 64];
          beat_idx++; gap_left = gap_cfg;
          if (beat_idx == 4) bursting = 0;
        end
      end else if (stray_done != stray_req) begin
        stray_done++;
        bmem_rvalid = 1'b1; bmem_raddr = stray_addr; bmem_rdata = 64'hFFFF_0000_FFFF_0000;
      end
      prev_wr = bmem_write;
    end
  end

  task automatic wait_resp(input string tag);
    int n = 0;
    while (!dfp_resp && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!dfp_resp) check({tag, "_timeout"}, 256'(1), '0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input int lat);
    logic [31:0] la = {addr[31:5], 5'b0};
    mem[la] = line;
    exp_ra.push_back(la);
    sb.push_back('{line, la, lat, cyc});
    last_rd = line;
    dfp_addr = addr; dfp_read = 1'b1;
    wait_resp("read");
    dfp_read = 1'b0; dfp_addr = $urandom;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int lat, input bit toggle);
    logic [31:0] la = {addr[31:5], 5'b0};
    wr_toggle_cfg = toggle;
    sb.push_back('{last_rd, la, lat, cyc});
    for (int k = 0; k < 4; k++) begin
      exp_wd.push_back(line[64*k +: 64]);
      exp_wa.push_back(la);
    end
    dfp_addr = addr; dfp_wdata = line; dfp_write = 1'b1;
    wait_resp("write");
    dfp_write = 1'b0; dfp_wdata = {8{$urandom}};
    @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [255:0] l1, l2, w1, w2, rl;
    logic [31:0]  a;
    rst_n = 1'b0; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_resp", 256'(dfp_resp), '0);
    check("rst_rdata", dfp_rdata, '0);
    check("rst_raddr", 256'(dfp_raddr), '0);
    check("rst_bmem_ctl", 256'({bmem_read, bmem_write}), '0);
    check("rst_bmem_addr", 256'(bmem_addr), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic read, zero stalls.
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h0000_1234, l1, 6);
    check("rdata_hold", dfp_rdata, l1);

    // Request stalled 3 cycles, beats spaced by 2 idle cycles.
    stall_cfg = 3; gap_cfg = 2;
    l2 = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    do_read(32'h0000_5A40, l2, 17);
    stall_cfg = 0; gap_cfg = 0;

    // Write with ready toggling 1,0,1,0...
    w1 = 256'hDEAD0000_11111111_22222222_33333333_44444444_55555555_66666666_7777BEEF;
    do_write(32'h0000_0080, w1, 8, 1'b1);

    // Read and write together: write first, read accepted right after.
    w2 = {4{64'h0123_4567_89AB_CDEF}};
    rl = {64'hC3C3_C3C3_0000_0000, 64'hC2C2_C2C2_0000_0000, 64'hC1C1_C1C1_0000_0000, 64'hC0C0_C0C0_0000_0000};
    wr_toggle_cfg = 1'b0;
    mem[32'h0000_0340] = rl;
    for (int k = 0; k < 4; k++) begin
      exp_wd.push_back(w2[64*k +: 64]);
      exp_wa.push_back(32'h0000_0200);
    end
    exp_ra.push_back(32'h0000_0340);
    sb.push_back('{last_rd, 32'h0000_0200, 5, cyc});
    sb.push_back('{rl, 32'h0000_0340, 12, cyc});
    dfp_addr = 32'h0000_0200; dfp_wdata = w2; dfp_write = 1'b1; dfp_read = 1'b1;
    wait_resp("both_wr");
    dfp_write = 1'b0; dfp_addr = 32'h0000_0340;
    @(negedge clk);
    wait_resp("both_rd");
    dfp_read = 1'b0;
    last_rd = rl;
    @(negedge clk);

    // Stray rvalid while idle, then a mismatched-address beat mid-burst.
    stray_addr = 32'h0000_7700;
    stray_req++;
    repeat (3) @(negedge clk);
    check("stray_no_resp", 256'(dfp_resp), '0);
    inject_cfg = 1'b1;
    do_read(32'h0000_771F, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 7);
    inject_cfg = 1'b0;

    // Reset while beat 2 of a read is on the bus.
    a = 32'h0000_4000;
    mem[a] = {4{64'hEEEE_EEEE_EEEE_EEEE}};
    exp_ra.push_back(a);
    dfp_addr = a; dfp_read = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; dfp_read = 1'b0;
    #1;
    check("mid_rst_resp", 256'(dfp_resp), '0);
    check("mid_rst_rdata", dfp_rdata, '0);
    check("mid_rst_raddr", 256'(dfp_raddr), '0);
    check("mid_rst_bmem_ctl", 256'({bmem_read, bmem_write}), '0);
    check("mid_rst_bmem_addr", 256'(bmem_addr), '0);
    check("mid_rst_bmem_wdata", 256'(bmem_wdata), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; last_rd = '0;
    @(negedge clk);
    do_read(32'h0000_4000, {64'h5, 64'h6, 64'h7, 64'h8}, 6);

    // A few back-to-back random operations.
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      if (i % 2 == 0) do_read(a, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 6);
      else do_write(a, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 5, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("sb_drained", 256'(sb.size()), '0);
    check("wr_beats_drained", 256'(exp_wd.size()), '0);
    check("rd_reqs_drained", 256'(exp_ra.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
